// File: rtl/dilithium_output_unpacker.sv
// 64-to-32 output unpacker: show-ahead FIFO of {last,data} beats, each beat re-emitted as two words.
// Build option DILITHIUM_UNPACK_BYTESWAP_EN byte-reverses every output word for big-endian hosts.
module dilithium_output_unpacker #(
   parameter int DEPTH     = 8,
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [63:0]              s_data,
   input  logic                     s_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [31:0]              m_data,
   output logic                     m_last,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              frame_words,
   output logic                     frame_done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [64:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        half_sel;
   logic [15:0] running;
   logic [64:0] head;
   logic [31:0] word_sel;
   logic        full, empty, push, hs;

   // Wrap bit distinguishes full from empty when the index bits coincide.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign s_ready = !full && !clear;
   assign push    = s_valid && s_ready;
   assign m_valid = !empty;
   assign hs      = m_valid && m_ready && !clear;
   assign level   = wr_ptr - rd_ptr;

   assign head   = mem[rd_ptr[AW-1:0]];
   assign m_last = head[64] && half_sel;

   always_comb begin
      word_sel = head[31:0];
      if (LOW_FIRST) word_sel = half_sel ? head[63:32] : head[31:0];
      else           word_sel = half_sel ? head[31:0]  : head[63:32];
   end

`ifdef DILITHIUM_UNPACK_BYTESWAP_EN
   assign m_data = {word_sel[7:0], word_sel[15:8], word_sel[23:16], word_sel[31:24]};
`else
   assign m_data = word_sel;
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         half_sel    <= 1'b0;
         running     <= '0;
         frame_words <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            half_sel <= 1'b0;
            running  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (hs) begin
               half_sel <= ~half_sel;
               if (half_sel) rd_ptr <= rd_ptr + PTR_ONE;
               // Frame count includes the closing word; both counters saturate.
               if (m_last) begin
                  frame_words <= (running == 16'hFFFF) ? 16'hFFFF : running + 16'd1;
                  running     <= '0;
                  frame_done  <= 1'b1;
               end else if (running != 16'hFFFF) begin
                  running <= running + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dilithium_output_unpacker.sv
// Directed bench for dilithium_output_unpacker (DEPTH=8, LOW_FIRST=1); honours DILITHIUM_UNPACK_BYTESWAP_EN.
module tb_dilithium_output_unpacker;

   logic        clk = 1'b0;
   logic        rst, clear, s_valid, s_ready, s_last, m_valid, m_ready, m_last, frame_done;
   logic [63:0] s_data;
   logic [31:0] m_data;
   logic [3:0]  level;
   logic [15:0] frame_words;

   int tests = 0;
   int fails = 0;

   dilithium_output_unpacker #(.DEPTH(8), .LOW_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .level(level), .frame_words(frame_words), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bs(input logic [31:0] w);
`ifdef DILITHIUM_UNPACK_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic logic [63:0] beat(input int i);
      return {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
   endfunction

   // Expected k-th word of a run of beats starting at index b0 (low half first).
   function automatic logic [31:0] wexp(input int b0, input int k);
      logic [63:0] b;
      b = beat(b0 + k / 2);
      return bs((k % 2 == 0) ? b[31:0] : b[63:32]);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] pat;
      int          k, done_cnt;
      rst = 1'b1; clear = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
      pat = 16'b1011_0010_1101_0110;

      // Reset state
      step(); step();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_frame_words", frame_words, 0);
      chk("rst_frame_done", frame_done, 0);
      rst = 1'b0;
      #1 chk("rst_s_ready", s_ready, 1);

      // 1: basic order
      s_valid = 1'b1; s_data = 64'h1111_2222_3333_4444; s_last = 1'b1; m_ready = 1'b1;
      step();
      s_valid = 1'b0; s_last = 1'b0;
      chk("t1_m_valid", m_valid, 1);
      chk("t1_w0", m_data, bs(32'h3333_4444));
      chk("t1_w0_last", m_last, 0);
      chk("t1_level", level, 1);
      step();
      chk("t1_w1", m_data, bs(32'h1111_2222));
      chk("t1_w1_last", m_last, 1);
      chk("t1_done_early", frame_done, 0);
      step();
      chk("t1_done", frame_done, 1);
      chk("t1_frame_words", frame_words, 2);
      chk("t1_empty", m_valid, 0);
      step();
      chk("t1_done_pulse", frame_done, 0);
      m_ready = 1'b0;

      // 2: fill, backpressure, pointer wrap
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1; s_data = beat(i); s_last = 1'b0;
         #1 chk("t2_s_ready_fill", s_ready, 1);
         step();
      end
      s_data = beat(8); s_last = 1'b1;
      #1 chk("t2_full_s_ready", s_ready, 0);
      chk("t2_full_level", level, 8);
      step();
      chk("t2_hold_level", level, 8);
      m_ready = 1'b1;
      for (int w = 0; w < 18; w++) begin
         chk("t2_m_valid", m_valid, 1);
         chk("t2_m_data", m_data, wexp(0, w));
         chk("t2_m_last", m_last, (w == 17));
         chk("t2_no_done", frame_done, 0);
         if (w < 2) chk("t2_s_ready_full", s_ready, 0);
         if (w == 2) begin
            chk("t2_s_ready_back", s_ready, 1);
            chk("t2_level_after_pop", level, 7);
         end
         if (w == 3) chk("t2_level_refill", level, 8);
         step();
         if (w == 2) begin s_valid = 1'b0; s_last = 1'b0; end
      end
      chk("t2_done", frame_done, 1);
      chk("t2_frame_words", frame_words, 18);
      chk("t2_level_end", level, 0);
      m_ready = 1'b0;

      // 3: stall stability over a 4-beat frame
      for (int j = 0; j < 4; j++) begin
         s_valid = 1'b1; s_data = beat(20 + j); s_last = (j == 3);
         step();
      end
      s_valid = 1'b0; s_last = 1'b0;
      k = 0; done_cnt = 0;
      for (int cyc = 0; cyc < 64 && k < 8; cyc++) begin
         m_ready = pat[cyc % 16];
         #1;
         chk("t3_m_valid", m_valid, 1);
         chk("t3_m_data", m_data, wexp(20, k));
         chk("t3_m_last", m_last, (k == 7));
         if (frame_done) done_cnt++;
         if (m_ready) k++;
         step();
      end
      m_ready = 1'b0;
      chk("t3_words_seen", k, 8);
      if (frame_done) done_cnt++;
      step();
      if (frame_done) done_cnt++;
      chk("t3_done_count", done_cnt, 1);
      chk("t3_frame_words", frame_words, 8);

      // 4: push and second-half pop at full
      for (int j = 0; j < 8; j++) begin
         s_valid = 1'b1; s_data = beat(30 + j); s_last = 1'b0;
         step();
      end
      s_valid = 1'b0; m_ready = 1'b1;
      step();
      s_valid = 1'b1; s_data = beat(40);
      #1 chk("t4_s_ready", s_ready, 0);
      chk("t4_level_full", level, 8);
      chk("t4_hi_word", m_data, wexp(30, 1));
      step();
      s_valid = 1'b0; m_ready = 1'b0;
      chk("t4_level", level, 7);
      chk("t4_next_head", m_data, wexp(30, 2));

      // 5: clear mid-frame
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t5_flush_level", level, 0);
      for (int j = 0; j < 3; j++) begin
         s_valid = 1'b1; s_data = beat(50 + j); s_last = 1'b0;
         step();
      end
      s_valid = 1'b0; m_ready = 1'b1;
      step();
      chk("t5_half1", m_data, wexp(50, 1));
      clear = 1'b1; s_valid = 1'b1; s_data = beat(60);
      #1 chk("t5_s_ready_clear", s_ready, 0);
      step();
      clear = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      chk("t5_m_valid", m_valid, 0);
      chk("t5_level", level, 0);
      chk("t5_frame_words_kept", frame_words, 8);
      chk("t5_frame_done", frame_done, 0);
      s_valid = 1'b1; s_data = beat(70); s_last = 1'b1;
      step();
      s_valid = 1'b0; s_last = 1'b0;
      chk("t5_half_reset", m_data, wexp(70, 0));
      chk("t5_last_w0", m_last, 0);
      m_ready = 1'b1;
      step();
      chk("t5_w1", m_data, wexp(70, 1));
      chk("t5_last_w1", m_last, 1);
      step();
      chk("t5_done", frame_done, 1);
      chk("t5_count_reset", frame_words, 2);
      m_ready = 1'b0;

      // 6: byte order of first word
      s_valid = 1'b1; s_data = 64'h0000_0000_1122_3344; s_last = 1'b1;
      step();
      s_valid = 1'b0; s_last = 1'b0;
`ifdef DILITHIUM_UNPACK_BYTESWAP_EN
      chk("t6_swap", m_data, 32'h4433_2211);
`else
      chk("t6_plain", m_data, 32'h1122_3344);
`endif
      m_ready = 1'b1;
      step(); step();
      chk("t6_drained", m_valid, 0);

      // Async reset mid-frame discards a half-emitted beat
      m_ready = 1'b0; s_valid = 1'b1; s_data = beat(80); s_last = 1'b0;
      step();
      s_valid = 1'b0; m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      #2 rst = 1'b1;
      #1 chk("t7_rst_m_valid", m_valid, 0);
      chk("t7_rst_level", level, 0);
      chk("t7_rst_frame_words", frame_words, 0);
      step();
      rst = 1'b0;
      s_valid = 1'b1; s_data = beat(90);
      step();
      s_valid = 1'b0;
      chk("t7_half_reset", m_data, wexp(90, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
